// File: rtl/jtag_dmi_dtm.sv
// rtl/jtag_dmi_dtm.sv - JTAG DTM (IDCODE/DTMCS/DMI/BYPASS) driving a DMI initiator, TAP oversampled on iClk.
// Optional macro DTM_TRST_EN adds the iTrst_n JTAG reset input.
module jtag_dmi_dtm #(
  parameter logic [31:0] IDCODE      = 32'h1000_0001,
  parameter int          ABITS       = 7,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iTck,
  input  logic             iTms,
  input  logic             iTdi,
`ifdef DTM_TRST_EN
  input  logic             iTrst_n,
`endif
  output logic             oTdo,
  output logic             oTdoEn,
  output logic             oDmReq,
  output logic             oDmWrite,
  output logic [ABITS-1:0] oDmAddr,
  output logic [31:0]      oDmWdata,
  input  logic             iDmAck,
  input  logic [31:0]      iDmRdata,
  input  logic             iDmErr
);

  localparam int DRW = ABITS + 34;
  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  typedef enum logic {DMI_IDLE, DMI_REQ} dmi_e;

  logic [SYNC_STAGES-1:0] r_tck_sync;
  logic [SYNC_STAGES-1:0] r_tms_sync;
  logic [SYNC_STAGES-1:0] r_tdi_sync;
  logic                   r_tck_d;
  logic                   w_tck_rise;
  logic                   w_tck_fall;
  logic                   w_tms;
  logic                   w_tdi;
  logic                   w_trst;

  tap_e                   r_tap;
  tap_e                   w_tap_next;
  logic [4:0]             r_ir;
  logic [4:0]             r_ir_sr;
  logic [DRW-1:0]         r_dr;
  logic [DRW-1:0]         w_dr_capture;
  logic [DRW-1:0]         w_dr_shift;
  logic [DRW:0]           w_dr_ext;
  int                     w_dr_len;

  dmi_e                   r_dmi;
  logic [1:0]             r_dmistat;
  logic [31:0]            r_rdata;
  logic                   r_discard;
  logic                   w_busy;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_tck_sync <= '0;
      r_tms_sync <= '0;
      r_tdi_sync <= '0;
      r_tck_d    <= 1'b0;
    end else begin
      r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], iTck};
      r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], iTms};
      r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], iTdi};
      r_tck_d    <= r_tck_sync[SYNC_STAGES-1];
    end
  end

`ifdef DTM_TRST_EN
  logic [SYNC_STAGES-1:0] r_trst_sync;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_trst_sync <= '0;
    else         r_trst_sync <= {r_trst_sync[SYNC_STAGES-2:0], iTrst_n};
  end

  assign w_trst = ~r_trst_sync[SYNC_STAGES-1];
`else
  assign w_trst = 1'b0;
`endif

  assign w_tck_rise = r_tck_sync[SYNC_STAGES-1] & ~r_tck_d;
  assign w_tck_fall = ~r_tck_sync[SYNC_STAGES-1] & r_tck_d;
  assign w_tms      = r_tms_sync[SYNC_STAGES-1];
  assign w_tdi      = r_tdi_sync[SYNC_STAGES-1];
  assign w_busy     = (r_dmi == DMI_REQ);

  always_comb begin
    w_tap_next = r_tap;
    case (r_tap)
      TLR:     w_tap_next = w_tms ? TLR    : RTI;
      RTI:     w_tap_next = w_tms ? SEL_DR : RTI;
      SEL_DR:  w_tap_next = w_tms ? SEL_IR : CAP_DR;
      CAP_DR:  w_tap_next = w_tms ? EX1_DR : SH_DR;
      SH_DR:   w_tap_next = w_tms ? EX1_DR : SH_DR;
      EX1_DR:  w_tap_next = w_tms ? UPD_DR : PAU_DR;
      PAU_DR:  w_tap_next = w_tms ? EX2_DR : PAU_DR;
      EX2_DR:  w_tap_next = w_tms ? UPD_DR : SH_DR;
      UPD_DR:  w_tap_next = w_tms ? SEL_DR : RTI;
      SEL_IR:  w_tap_next = w_tms ? TLR    : CAP_IR;
      CAP_IR:  w_tap_next = w_tms ? EX1_IR : SH_IR;
      SH_IR:   w_tap_next = w_tms ? EX1_IR : SH_IR;
      EX1_IR:  w_tap_next = w_tms ? UPD_IR : PAU_IR;
      PAU_IR:  w_tap_next = w_tms ? EX2_IR : PAU_IR;
      EX2_IR:  w_tap_next = w_tms ? UPD_IR : SH_IR;
      UPD_IR:  w_tap_next = w_tms ? SEL_DR : RTI;
      default: w_tap_next = TLR;
    endcase
  end

  // One physical DR shifter; the selected register sets its active length and capture value.
  always_comb begin
    w_dr_len     = 1;
    w_dr_capture = '0;
    case (r_ir)
      IR_IDCODE: begin
        w_dr_len     = 32;
        w_dr_capture = DRW'(IDCODE);
      end
      IR_DTMCS: begin
        w_dr_len     = 32;
        w_dr_capture = DRW'({17'd0, 3'd1, r_dmistat, 6'(ABITS), 4'd1});
      end
      IR_DMI: begin
        w_dr_len     = DRW;
        w_dr_capture = {oDmAddr, r_rdata, (w_busy ? 2'd3 : r_dmistat)};
      end
      default: begin
        w_dr_len     = 1;
        w_dr_capture = '0;
      end
    endcase
  end

  assign w_dr_ext = {1'b0, r_dr};

  always_comb begin
    w_dr_shift = '0;
    for (int i = 0; i < DRW; i++) begin
      if (i == w_dr_len - 1)     w_dr_shift[i] = w_tdi;
      else if (i < w_dr_len - 1) w_dr_shift[i] = w_dr_ext[i+1];
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_tap     <= TLR;
      r_ir      <= IR_IDCODE;
      r_ir_sr   <= '0;
      r_dr      <= '0;
      oTdo      <= 1'b0;
      oTdoEn    <= 1'b0;
      r_dmi     <= DMI_IDLE;
      oDmReq    <= 1'b0;
      oDmWrite  <= 1'b0;
      oDmAddr   <= '0;
      oDmWdata  <= '0;
      r_dmistat <= 2'd0;
      r_rdata   <= '0;
      r_discard <= 1'b0;
    end else begin
      if (w_busy && iDmAck) begin
        r_dmi     <= DMI_IDLE;
        oDmReq    <= 1'b0;
        r_discard <= 1'b0;
        if (!r_discard) begin
          if (!oDmWrite) r_rdata <= iDmRdata;
          if (iDmErr)    r_dmistat <= 2'd2;
        end
      end

      if (w_trst) begin
        r_tap <= TLR;
        r_ir  <= IR_IDCODE;
      end else if (w_tck_rise) begin
        r_tap <= w_tap_next;
        case (r_tap)
          TLR:    r_ir    <= IR_IDCODE;
          CAP_IR: r_ir_sr <= 5'b00001;
          SH_IR:  r_ir_sr <= {w_tdi, r_ir_sr[4:1]};
          UPD_IR: r_ir    <= r_ir_sr;
          CAP_DR: begin
            r_dr <= w_dr_capture;
            if (r_ir == IR_DMI && w_busy) r_dmistat <= 2'd3;
          end
          SH_DR:  r_dr <= w_dr_shift;
          UPD_DR: begin
            if (r_ir == IR_DTMCS) begin
              if (r_dr[16] || r_dr[17]) r_dmistat <= 2'd0;
              if (r_dr[17] && w_busy && !iDmAck) r_discard <= 1'b1;
            end else if (r_ir == IR_DMI && r_dmistat == 2'd0) begin
              if (w_busy) begin
                r_dmistat <= 2'd3;
              end else if (r_dr[1:0] == 2'd1 || r_dr[1:0] == 2'd2) begin
                r_dmi    <= DMI_REQ;
                oDmReq   <= 1'b1;
                oDmWrite <= (r_dr[1:0] == 2'd2);
                oDmAddr  <= r_dr[DRW-1:34];
                oDmWdata <= r_dr[33:2];
              end
            end
          end
          default: ;
        endcase
      end else if (r_tap == TLR) begin
        r_ir <= IR_IDCODE;
      end

      if (w_tck_fall) begin
        oTdoEn <= (r_tap == SH_IR) || (r_tap == SH_DR);
        oTdo   <= (r_tap == SH_IR) ? r_ir_sr[0] : (r_tap == SH_DR) ? r_dr[0] : 1'b0;
      end
    end
  end

endmodule
